// File: rtl/counter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : counter_pkg
// Brief    : Shared defaults and direction encoding for the directional counter.
// Revision : 1.0 - initial release
// ============================================================================
package counter_pkg;

    localparam int DEFAULT_WIDTH         = 8;
    localparam int DEFAULT_ROM_ADDR_BITS = 8;

    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

endpackage : counter_pkg
`default_nettype wire

// File: rtl/count_lut_rom.sv
`default_nettype none
// ============================================================================
// Module   : count_lut_rom
// Brief    : Synchronous identity ROM, mem[a] = a[WIDTH-1:0], one-cycle read.
// Revision : 1.0 - initial release
// ============================================================================
module count_lut_rom
    import counter_pkg::*;
#(
    parameter int WIDTH         = DEFAULT_WIDTH,
    parameter int ROM_ADDR_BITS = DEFAULT_ROM_ADDR_BITS
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     ROM_EN,
    input  logic [ROM_ADDR_BITS-1:0] ROM_ADDR,
    output logic [WIDTH-1:0]         ROM_DATA
);

    localparam int DEPTH = 2 ** ROM_ADDR_BITS;

    logic [WIDTH-1:0] w_mem [DEPTH];

    // Contents are fixed at elaboration; the slice also rejects ROM_ADDR_BITS < WIDTH.
    for (genvar a = 0; a < DEPTH; a++) begin : g_rom_init
        localparam logic [ROM_ADDR_BITS-1:0] c_addr = ROM_ADDR_BITS'(a);
        assign w_mem[a] = c_addr[WIDTH-1:0];
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            ROM_DATA <= '0;
        end else if (ROM_EN) begin
            ROM_DATA <= w_mem[ROM_ADDR];
        end
    end

endmodule : count_lut_rom
`default_nettype wire

// File: rtl/counter_top_8b.sv
`default_nettype none
// ============================================================================
// Module   : counter_top_8b
// Brief    : Wrapping up/down counter with terminal count and reference ROM.
// Revision : 1.0 - initial release
// ============================================================================
module counter_top_8b
    import counter_pkg::*;
#(
    parameter int WIDTH         = DEFAULT_WIDTH,
    parameter int ROM_ADDR_BITS = DEFAULT_ROM_ADDR_BITS
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     EN,
    input  logic                     DIR,
    output logic [WIDTH-1:0]         CNT,
    output logic                     TC,
    input  logic                     ROM_EN,
    input  logic [ROM_ADDR_BITS-1:0] ROM_ADDR,
    output logic [WIDTH-1:0]         ROM_DATA
);

    logic w_cnt_max;
    logic w_cnt_zero;

    // CNT is the count register itself so it can be reached hierarchically.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            CNT <= '0;
        end else if (EN) begin
            if (DIR == DIR_DOWN) begin
                CNT <= CNT - WIDTH'(1);
            end else begin
                CNT <= CNT + WIDTH'(1);
            end
        end
    end

    assign w_cnt_max  = (CNT == {WIDTH{1'b1}});
    assign w_cnt_zero = (CNT == '0);

    // High in the cycle before the counter wraps in the selected direction.
    assign TC = EN & (((DIR == DIR_UP) & w_cnt_max) | ((DIR == DIR_DOWN) & w_cnt_zero));

    count_lut_rom #(
        .WIDTH         (WIDTH),
        .ROM_ADDR_BITS (ROM_ADDR_BITS)
    ) u_rom (
        .CLK      (CLK),
        .RST      (RST),
        .ROM_EN   (ROM_EN),
        .ROM_ADDR (ROM_ADDR),
        .ROM_DATA (ROM_DATA)
    );

endmodule : counter_top_8b
`default_nettype wire

// File: tb/tb_counter_top_8b.sv
`default_nettype none
// ============================================================================
// Module   : tb_counter_top_8b
// Brief    : Directed self-checking bench for counter_top_8b.
// Revision : 1.0 - initial release
// ============================================================================
module tb_counter_top_8b;

    logic       CLK = 1'b0;
    logic       RST;
    logic       EN;
    logic       DIR;
    logic       ROM_EN;
    logic [7:0] ROM_ADDR;
    logic [7:0] CNT;
    logic [7:0] ROM_DATA;
    logic       TC;

    int n_tests = 0;
    int n_fail  = 0;

    // Where the ROM address pointer should be; drives ROM_ADDR half a cycle ahead.
    logic [7:0] addr_trk;

    always #5 CLK = ~CLK;

    counter_top_8b #(
        .WIDTH         (8),
        .ROM_ADDR_BITS (8)
    ) dut (
        .CLK      (CLK),
        .RST      (RST),
        .EN       (EN),
        .DIR      (DIR),
        .CNT      (CNT),
        .TC       (TC),
        .ROM_EN   (ROM_EN),
        .ROM_ADDR (ROM_ADDR),
        .ROM_DATA (ROM_DATA)
    );

    task automatic tick();
        if (EN) addr_trk = DIR ? addr_trk - 8'd1 : addr_trk + 8'd1;
        ROM_ADDR = addr_trk;
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        RST      = 1'b1;
        EN       = 1'b0;
        DIR      = 1'b0;
        addr_trk = 8'h00;
        ROM_ADDR = 8'h00;
        repeat (2) @(posedge CLK);
        #1;
        RST = 1'b0;
    endtask

    task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    initial begin
        ROM_EN = 1'b1;
        do_reset();
        chk8("reset_cnt", CNT, 8'h00);
        chk8("reset_rom", ROM_DATA, 8'h00);
        chk1("reset_tc", TC, 1'b0);

        // Up count 0x01..0x0A with the ROM tracking the count
        EN  = 1'b1;
        DIR = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            tick();
            chk8("up_cnt", CNT, 8'(i));
            chk8("up_rom", ROM_DATA, 8'(i));
        end
        chk1("up_tc_mid", TC, 1'b0);

        // Force CNT to 0 for one edge; expected 0x0B is lost
        force dut.CNT = 8'h00;
        tick();
        chk8("force_cnt", CNT, 8'h00);
        chk8("force_rom", ROM_DATA, 8'h0B);
        release dut.CNT;
        tick();
        chk8("post_force_cnt", CNT, 8'h01);
        chk8("post_force_rom", ROM_DATA, 8'h0C);
        addr_trk = 8'h01;
        tick();
        chk8("realign_cnt", CNT, 8'h02);
        chk8("realign_rom", ROM_DATA, 8'h02);

        // Hold and direction flip
        do_reset();
        EN  = 1'b1;
        DIR = 1'b0;
        repeat (5) tick();
        chk8("pre_hold_cnt", CNT, 8'h05);
        EN = 1'b0;
        repeat (5) tick();
        chk8("hold_cnt", CNT, 8'h05);
        chk8("hold_rom", ROM_DATA, 8'h05);
        ROM_EN   = 1'b0;
        ROM_ADDR = 8'h99;
        @(posedge CLK);
        #1;
        chk8("rom_en_hold", ROM_DATA, 8'h05);
        ROM_EN = 1'b1;
        EN  = 1'b1;
        DIR = 1'b1;
        tick();
        chk8("flip_down_cnt", CNT, 8'h04);
        DIR = 1'b0;
        tick();
        chk8("flip_up_cnt", CNT, 8'h05);
        chk8("flip_up_rom", ROM_DATA, 8'h05);

        // Down count and wrap below zero
        do_reset();
        EN  = 1'b1;
        DIR = 1'b1;
        #1;
        chk1("down_tc_at0", TC, 1'b1);
        tick();
        chk8("down_cnt_ff", CNT, 8'hFF);
        chk1("down_tc_ff", TC, 1'b0);
        tick();
        chk8("down_cnt_fe", CNT, 8'hFE);
        tick();
        chk8("down_cnt_fd", CNT, 8'hFD);
        chk8("down_rom_fd", ROM_DATA, 8'hFD);

        // Up wrap through 0xFF
        do_reset();
        EN  = 1'b1;
        DIR = 1'b0;
        repeat (254) tick();
        chk8("wrap_cnt_fe", CNT, 8'hFE);
        chk1("wrap_tc_fe", TC, 1'b0);
        tick();
        chk8("wrap_cnt_ff", CNT, 8'hFF);
        chk1("wrap_tc_ff", TC, 1'b1);
        tick();
        chk8("wrap_cnt_00", CNT, 8'h00);
        chk1("wrap_tc_00", TC, 1'b0);
        chk8("wrap_rom_00", ROM_DATA, 8'h00);

        // Asynchronous reset between edges
        do_reset();
        EN  = 1'b1;
        DIR = 1'b0;
        repeat (8'h37) tick();
        chk8("pre_arst_cnt", CNT, 8'h37);
        chk8("pre_arst_rom", ROM_DATA, 8'h37);
        #2;
        RST = 1'b1;
        #1;
        chk8("arst_cnt", CNT, 8'h00);
        chk8("arst_rom", ROM_DATA, 8'h00);
        @(posedge CLK);
        #1;
        chk8("arst_hold_cnt", CNT, 8'h00);
        chk8("arst_hold_rom", ROM_DATA, 8'h00);
        RST = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_counter_top_8b
`default_nettype wire

// File: doc/counter_top_8b.md
Name:
counter_top_8b

Overview:
- Directional up/down binary counter (default 8 bits) with count-enable and direction control.
- Packaged with a synchronous lookup ROM submodule. The ROM holds the identity count sequence, so a bench (or system-level checker) can read the expected count value alongside the live count.
- Used as a small datapath primitive wherever a wrapping directional count is needed.

Parameters:
- WIDTH, 8, counter width and ROM data width.
- ROM_ADDR_BITS, 8, ROM address width; ROM depth = 2**ROM_ADDR_BITS. Must be >= WIDTH.

Ports:
- CLK  in  1  rising-edge clock for all state.
- RST  in  1  asynchronous, active-high reset; clears all state.
- EN  in  1  count enable; counter advances only when 1.
- DIR  in  1  direction: 0 = up (+1), 1 = down (-1).
- CNT  out  WIDTH  current counter value (registered).
- TC  out  1  terminal count, combinational.
- ROM_EN  in  1  ROM read enable.
- ROM_ADDR  in  ROM_ADDR_BITS  ROM read address.
- ROM_DATA  out  WIDTH  registered ROM read data.

Behaviour:
- Reset: RST=1 forces CNT=0 and ROM_DATA=0 immediately, independent of CLK. Both hold at 0 while RST=1. Reset mid-count abandons the count; no other state exists.
- Counter register is named CNT internally, so hierarchical force/release of the count register is possible from a bench.
- Rising CLK edge with RST=0:
  - EN=0: CNT holds.
  - EN=1, DIR=0: CNT <= CNT+1, modulo 2**WIDTH.
  - EN=1, DIR=1: CNT <= CNT-1, modulo 2**WIDTH.
- Wrap-around: up from 2**WIDTH-1 (0xFF) gives 0x00; down from 0x00 gives 0xFF. No saturation, no sticky flags.
- Direction change takes effect on the next enabled edge; there is no turnaround delay.
- Latency: CNT reflects an enabled edge on that edge, i.e. one register stage.
- First edge after reset release with EN=1, DIR=0 gives CNT=1. With DIR=1 it gives CNT=0xFF.
- TC = EN & ((~DIR & CNT==all-ones) | (DIR & CNT==0)). TC is high in the cycle before a wrap.
- ROM contents: mem[a] = a[WIDTH-1:0] for every address a, initialised at elaboration. Contents are read-only and have no write port.
- ROM read: on a rising CLK edge with ROM_EN=1, ROM_DATA <= mem[ROM_ADDR]. With ROM_EN=0, ROM_DATA holds. One-cycle read latency.
- If ROM_ADDR tracks the counter (same direction, same enables, advanced half a cycle earlier), ROM_DATA equals CNT at every rising edge. This is the system-level checking invariant.
- No X propagation: outputs are defined from reset onward; inputs are sampled only at the clock edge.

Decomposition:
- Shared package counter_pkg holds:
  - Default WIDTH and ROM_ADDR_BITS constants.
  - Direction encoding constants DIR_UP=1'b0 and DIR_DOWN=1'b1.
- One submodule, count_lut_rom: the synchronous identity ROM (CLK, RST, ROM_EN, ROM_ADDR, ROM_DATA) with depth and width parameters.
- The counter and TC logic live in counter_top_8b, which instantiates count_lut_rom.

Test Plan:
- Reset then up count: RST=1 for 2 cycles, then RST=0, EN=1, DIR=0 for 10 edges -> CNT=0x01..0x0A. Checker-driven ROM_ADDR sequence gives ROM_DATA==CNT on every edge.
- Up wrap: start from CNT=0xFE, DIR=0, EN=1 -> 0xFF (TC=1 while at 0xFF), then 0x00 (TC=0).
- Down count and wrap: after reset, DIR=1, EN=1 -> CNT=0xFF, 0xFE, 0xFD. TC=1 only while CNT=0x00.
- Hold and direction flip: EN=0 for 5 edges at CNT=0x05 -> stays 0x05. Then EN=1, DIR=1 -> 0x04. Then DIR=0 -> 0x05.
- Error-check sanity: force internal CNT to 0 for one edge mid up-count (expected 0x0B) -> checker flags a mismatch. After release, counting resumes from the forced value and the mismatch persists until the ROM address is realigned.
- Async reset mid-count: assert RST between clock edges at CNT=0x37 -> CNT and ROM_DATA become 0x00 before the next edge and stay 0 while RST=1.
